forward_select_unit: RTL

- Producer side of the EX-stage operand 4x1 32-bit muxes in the RV32IM 5-stage pipeline.
- Tracks destination registers of instructions in flight through EX, MEM and WB.
- Generates registered 2-bit SELECT codes for the rs1 and rs2 operand muxes.
- Detects load-use hazards and asserts a stall, with bubble insertion.

---
 rtl/forward_select_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/forward_select_unit.sv
// EX-stage operand forwarding control: tracks in-flight destination registers,
// produces registered rs1/rs2 bypass selects and a combinational load-use stall.

module fsu_sel_lane #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int STAGES     = 3
) (
  input  logic [REG_ADDR_W-1:0]             rs,
  input  logic                              use_rs,
  input  logic [STAGES:1]                   wr_vld,
  input  logic [STAGES:1][REG_ADDR_W-1:0]   ent_rd,
  output logic [SEL_W-1:0]                  sel
);
  logic [STAGES:1] hit;

  for (genvar s = 1; s <= STAGES; s++) begin : g_hit
    assign hit[s] = wr_vld[s] & (ent_rd[s] != '0) & (ent_rd[s] == rs) & use_rs;
  end

  // Walk oldest to youngest so the youngest match wins; stage index is the code.
  always_comb begin
    sel = '0;
    for (int s = STAGES; s >= 1; s--) begin
      if (hit[s]) sel = SEL_W'(s);
    end
  end
endmodule

module forward_select_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USE_RS1,
  input  logic                  ID_USE_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  FLUSH,
  output logic [SEL_W-1:0]      FWD_SEL1,
  output logic [SEL_W-1:0]      FWD_SEL2,
  output logic                  LOAD_USE_STALL
);
  localparam int STAGES = 3;  // 1=EX, 2=MEM, 3=WB
  localparam int NOPS   = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } trk_t;

  trk_t [STAGES:1]                  trk_q, trk_d;
  logic [STAGES:1]                  vld_pipe_q, vld_pipe_d;
  trk_t                             new_ent;
  logic                             new_vld;
  logic                             stall;
  logic [STAGES:1]                  wr_vld;
  logic [STAGES:1][REG_ADDR_W-1:0]  ent_rd;
  logic [NOPS-1:0][REG_ADDR_W-1:0]  rs_vec;
  logic [NOPS-1:0]                  use_vec;
  logic [NOPS-1:0][SEL_W-1:0]       sel_c, sel_d, sel_q;

  assign rs_vec  = {ID_RS2, ID_RS1};
  assign use_vec = {ID_USE_RS2, ID_USE_RS1};

  // Only a load sitting in EX can hazard; anything older is covered by bypass.
  always_comb begin
    stall = ID_VALID & ~FLUSH & vld_pipe_q[1] & trk_q[1].mem_read & (trk_q[1].rd != '0) &
            ((ID_USE_RS1 & (trk_q[1].rd == ID_RS1)) | (ID_USE_RS2 & (trk_q[1].rd == ID_RS2)));
  end
  assign LOAD_USE_STALL = stall;

  assign new_vld = ID_VALID & ~stall & ~FLUSH;

  always_comb begin
    new_ent = '0;
    if (new_vld) begin
      new_ent.rd        = ID_RD;
      new_ent.reg_write = ID_REG_WRITE;
      new_ent.mem_read  = ID_MEM_READ;
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_ent
    assign wr_vld[s] = vld_pipe_q[s] & trk_q[s].reg_write;
    assign ent_rd[s] = trk_q[s].rd;
  end

  for (genvar g = 0; g < NOPS; g++) begin : g_lane
    fsu_sel_lane #(
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W),
      .STAGES     (STAGES)
    ) u_lane (
      .rs     (rs_vec[g]),
      .use_rs (use_vec[g]),
      .wr_vld (wr_vld),
      .ent_rd (ent_rd),
      .sel    (sel_c[g])
    );
  end

  always_comb begin
    trk_d[1] = new_ent;
    for (int s = 2; s <= STAGES; s++) trk_d[s] = trk_q[s-1];
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], new_vld};
    // A bubble entering EX carries no operands, so its selects are zero.
    sel_d = new_vld ? sel_c : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      trk_q      <= '0;
      vld_pipe_q <= '0;
      sel_q      <= '0;
    end else begin
      trk_q      <= trk_d;
      vld_pipe_q <= vld_pipe_d;
      sel_q      <= sel_d;
    end
  end

  assign FWD_SEL1 = sel_q[0];
  assign FWD_SEL2 = sel_q[1];
endmodule
